// File: rtl/mvu_pe_popcnt_acc.sv
// Popcount-accumulate stage of a binarised MVU PE: counts XNOR ones per beat, sums SF beats per word.
// Define MVU_POPCNT_BIPOLAR_EN to emit the signed +/-1 dot product (2*sum - SIMD*SF) instead.
module mvu_pe_popcnt_acc #(
  parameter int unsigned SIMD  = 8,
  parameter int unsigned SF    = 4,
  parameter int unsigned TDstI = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_v,
  output logic             in_rdy,
  input  logic [SIMD-1:0]  in_xnor,
  output logic             out_v,
  input  logic             out_rdy,
  output logic [TDstI-1:0] out
);

  localparam int unsigned CW = $clog2(SIMD + 1);
  localparam int unsigned FW = (SF > 1) ? $clog2(SF) : 1;

  logic              adv;
  logic [CW-1:0]     cnt;
  logic [FW-1:0]     fold_cnt;
  logic              fold_last;
  logic              p1_v;
  logic [CW-1:0]     p1_cnt;
  logic              p1_last;
  logic [TDstI-1:0]  acc;
  logic              acc_empty;
  logic [TDstI-1:0]  sum;
  logic [TDstI-1:0]  res;

  assign adv       = !out_v || out_rdy;
  assign in_rdy    = adv;
  assign fold_last = (fold_cnt == FW'(SF - 1));

  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(SIMD); i++) begin
      cnt = cnt + CW'(in_xnor[i]);
    end
  end

  // First beat of a fold starts from zero, so acc needs no explicit clear.
  assign sum = (acc_empty ? '0 : acc) + TDstI'(p1_cnt);

`ifdef MVU_POPCNT_BIPOLAR_EN
  assign res = (sum << 1) - TDstI'(SIMD * SF);
`else
  assign res = sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fold_cnt  <= '0;
      p1_v      <= 1'b0;
      p1_cnt    <= '0;
      p1_last   <= 1'b0;
      acc       <= '0;
      acc_empty <= 1'b1;
      out_v     <= 1'b0;
      out       <= '0;
    end else if (adv) begin
      p1_v    <= in_v;
      p1_cnt  <= cnt;
      p1_last <= fold_last;
      if (in_v) begin
        fold_cnt <= fold_last ? '0 : fold_cnt + FW'(1);
      end
      if (p1_v && p1_last) begin
        out       <= res;
        out_v     <= 1'b1;
        acc_empty <= 1'b1;
      end else begin
        if (p1_v) begin
          acc       <= sum;
          acc_empty <= 1'b0;
        end
        if (out_rdy) begin
          out_v <= 1'b0;
        end
      end
    end
  end

endmodule
